// File: rtl/gray_counter_param_if.sv
// Control/status bundle for gray_counter_param. With GRAY_COUNTER_RX_SYNC_EN
// it also carries the foreign-domain Gray pointer and its decoded binary value.
interface gray_counter_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc;
`ifdef GRAY_COUNTER_RX_SYNC_EN
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_rx;

  modport master (output en, up, load, load_val, gray_in,
                  input  bin_q, gray_q, tc, bin_rx);
  modport slave  (input  en, up, load, load_val, gray_in,
                  output bin_q, gray_q, tc, bin_rx);
`else
  modport master (output en, up, load, load_val,
                  input  bin_q, gray_q, tc);
  modport slave  (input  en, up, load, load_val,
                  output bin_q, gray_q, tc);
`endif
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised binary/Gray up-down counter with load, wrap/saturate and tc.
// Optional GRAY_COUNTER_RX_SYNC_EN adds a 2-flop Gray synchroniser and decoder.
module gray_counter_param #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned SATURATE    = 0
) (
  input logic                  clk,
  input logic                  reset,
  gray_counter_param_if.slave  bus
);
  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic [WIDTH-1:0] w_bin_nxt;
  logic             w_tc_nxt;

  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (bus.load) begin
      w_bin_nxt = bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (r_bin == MAX_VAL) begin
          w_tc_nxt  = 1'b1;
          w_bin_nxt = (SATURATE != 0) ? r_bin : '0;
        end else begin
          w_bin_nxt = r_bin + 1'b1;
        end
      end else begin
        if (r_bin == '0) begin
          w_tc_nxt  = 1'b1;
          w_bin_nxt = (SATURATE != 0) ? r_bin : MAX_VAL;
        end else begin
          w_bin_nxt = r_bin - 1'b1;
        end
      end
    end
  end

  // Gray is encoded from next-state binary so both registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
      r_tc   <= w_tc_nxt;
    end
  end

  assign bus.bin_q  = r_bin;
  assign bus.gray_q = r_gray;
  assign bus.tc     = r_tc;

`ifdef GRAY_COUNTER_RX_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_bin_rx;
  logic [WIDTH-1:0] w_rx_bin;

  always_comb begin
    w_rx_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rx_bin[i] = ^(r_sync2 >> i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_bin_rx <= '0;
    end else begin
      r_sync1  <= bus.gray_in;
      r_sync2  <= r_sync1;
      r_bin_rx <= w_rx_bin;
    end
  end

  assign bus.bin_rx = r_bin_rx;
`endif
endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// pops and compares them after each rising edge.
module tb_gray_counter_param;
  typedef struct {
    int unsigned sel;
    logic [3:0]  bin;
    logic [3:0]  gray;
    logic        tc;
    logic        step;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [3:0] prev_gray0;

  gray_counter_param_if #(.WIDTH(4)) bus0 ();
  gray_counter_param_if #(.WIDTH(4)) bus1 ();

  gray_counter_param #(.WIDTH(4), .RESET_VALUE(5), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  gray_counter_param #(.WIDTH(4), .RESET_VALUE(5), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input int unsigned sel, input logic [3:0] b,
                      input logic [3:0] gr, input logic t, input logic st);
    exp_t e;
    e.sel = sel; e.bin = b; e.gray = gr; e.tc = t; e.step = st;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic en, input logic up, input logic ld, input logic [3:0] lv);
    @(negedge clk);
    bus0.en = en; bus0.up = up; bus0.load = ld; bus0.load_val = lv;
    bus1.en = en; bus1.up = up; bus1.load = ld; bus1.load_val = lv;
  endtask

  initial begin
    prev_gray0 = '0;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.sel == 0) begin
          chk("dut0_bin", bus0.bin_q, e.bin);
          chk("dut0_gray", bus0.gray_q, e.gray);
          chk("dut0_tc", bus0.tc, e.tc);
          if (e.step)
            chk("dut0_gray_onebit", $countones(bus0.gray_q ^ prev_gray0), 1);
        end else if (e.sel == 1) begin
          chk("dut1_bin", bus1.bin_q, e.bin);
          chk("dut1_gray", bus1.gray_q, e.gray);
          chk("dut1_tc", bus1.tc, e.tc);
        end else begin
`ifdef GRAY_COUNTER_RX_SYNC_EN
          chk("bin_rx", bus0.bin_rx, e.bin);
`endif
        end
      end
      chk("dut0_invariant", bus0.gray_q, bus0.bin_q ^ (bus0.bin_q >> 1));
      chk("dut1_invariant", bus1.gray_q, bus1.bin_q ^ (bus1.bin_q >> 1));
      prev_gray0 = bus0.gray_q;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus0.en = 0; bus0.up = 0; bus0.load = 0; bus0.load_val = '0;
    bus1.en = 0; bus1.up = 0; bus1.load = 0; bus1.load_val = '0;
`ifdef GRAY_COUNTER_RX_SYNC_EN
    bus0.gray_in = '0;
    bus1.gray_in = '0;
`endif
    #1;
    chk("rst_bin", bus0.bin_q, 4'd5);
    chk("rst_gray", bus0.gray_q, 4'b0111);
    chk("rst_tc", bus0.tc, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // count a little, then reset asynchronously between edges
    cyc(1, 1, 0, 4'd0); push(0, 4'd6, 4'b0101, 0, 1);
    cyc(1, 1, 0, 4'd0); push(0, 4'd7, 4'b0100, 0, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_bin0", bus0.bin_q, 4'd5);
    chk("midrst_gray0", bus0.gray_q, 4'b0111);
    chk("midrst_tc0", bus0.tc, 1'b0);
    chk("midrst_bin1", bus1.bin_q, 4'd5);
    @(negedge clk);
    reset = 1'b0;
    push(0, 4'd6, 4'b0101, 0, 1);
    push(1, 4'd6, 4'b0101, 0, 0);

    // up across the top limit
    cyc(0, 0, 1, 4'd14); push(0, 4'd14, 4'b1001, 0, 0); push(1, 4'd14, 4'b1001, 0, 0);
    cyc(1, 1, 0, 4'd0);  push(0, 4'd15, 4'b1000, 0, 1); push(1, 4'd15, 4'b1000, 0, 0);
    cyc(1, 1, 0, 4'd0);  push(0, 4'd0,  4'b0000, 1, 1); push(1, 4'd15, 4'b1000, 1, 0);
    cyc(1, 1, 0, 4'd0);  push(0, 4'd1,  4'b0001, 0, 1); push(1, 4'd15, 4'b1000, 1, 0);

    // down across the bottom limit
    cyc(0, 0, 1, 4'd1);  push(0, 4'd1,  4'b0001, 0, 0); push(1, 4'd1, 4'b0001, 0, 0);
    cyc(1, 0, 0, 4'd0);  push(0, 4'd0,  4'b0000, 0, 1); push(1, 4'd0, 4'b0000, 0, 0);
    cyc(1, 0, 0, 4'd0);  push(0, 4'd15, 4'b1000, 1, 1); push(1, 4'd0, 4'b0000, 1, 0);
    cyc(1, 0, 0, 4'd0);  push(0, 4'd14, 4'b1001, 0, 1); push(1, 4'd0, 4'b0000, 1, 0);

    // load beats enable and clears tc; then idle hold
    cyc(1, 1, 1, 4'd9);  push(0, 4'd9, 4'b1101, 0, 0); push(1, 4'd9, 4'b1101, 0, 0);
    cyc(0, 1, 0, 4'd3);  push(0, 4'd9, 4'b1101, 0, 0); push(1, 4'd9, 4'b1101, 0, 0);

    // full sweep up then down on the wrapping counter
    cyc(0, 0, 1, 4'd0);  push(0, 4'd0, 4'b0000, 0, 0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = 4'((k + 1) % 16);
      cyc(1, 1, 0, 4'd0);
      push(0, b, g(b), (b == 4'd0), 1);
    end
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = 4'(15 - k);
      cyc(1, 0, 0, 4'd0);
      push(0, b, g(b), (k == 0), 1);
    end
    cyc(0, 0, 0, 4'd0);

`ifdef GRAY_COUNTER_RX_SYNC_EN
    @(negedge clk);
    bus0.gray_in = 4'b1101;
    push(2, 4'd0, 4'd0, 0, 0);
    @(negedge clk); push(2, 4'd0, 4'd0, 0, 0);
    @(negedge clk); push(2, 4'd9, 4'd0, 0, 0);
    @(negedge clk); push(2, 4'd9, 4'd0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rx_midrst", bus0.bin_rx, 4'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised binary/Gray up-down counter.
- Registered binary and Gray outputs, always consistent with each other.
- Supports synchronous load, wrap or saturate at the limits, and a terminal-count flag.
- Used as the pointer/position source for cross-clock-domain logic. Gray output is glitch-free: exactly one bit changes per count step.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- RESET_VALUE, 0, binary value loaded on reset (Gray outputs reset to its Gray encoding).
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- bin_q  output  WIDTH  registered binary count.
- gray_q  output  WIDTH  registered Gray count, equal to bin_q ^ (bin_q >> 1).
- tc  output  1  registered terminal-count flag, one-cycle pulse.

Behaviour:
- Reset (asynchronous, active-high, clock is clk):
  - bin_q = RESET_VALUE, gray_q = RESET_VALUE ^ (RESET_VALUE >> 1), tc = 0.
  - Reset asserted mid-count clears immediately with no clock needed. The first count after deassertion starts from RESET_VALUE.
- Priority per rising edge is load > en > hold.
- load=1:
  - bin_q <= load_val and gray_q <= Gray(load_val) in the same edge. tc <= 0.
  - en and up are ignored that cycle.
- en=1, load=0, up=1:
  - If bin_q != 2^WIDTH-1: bin_q <= bin_q+1.
  - If bin_q == 2^WIDTH-1 and SATURATE=0: bin_q <= 0, tc <= 1.
  - If bin_q == 2^WIDTH-1 and SATURATE=1: bin_q holds, tc <= 1.
- en=1, load=0, up=0:
  - If bin_q != 0: bin_q <= bin_q-1.
  - If bin_q == 0 and SATURATE=0: bin_q <= 2^WIDTH-1, tc <= 1.
  - If bin_q == 0 and SATURATE=1: bin_q holds, tc <= 1.
- en=0, load=0: all state holds, tc <= 0.
- tc is high for exactly one cycle per limit event. It coincides with the cycle bin_q shows the wrapped (or held) value. Holding en at a saturated limit re-asserts tc every cycle.
- Latency:
  - gray_q is computed from next-state binary and registered on the same edge as bin_q. There is no extra cycle of lag between them.
  - Invariant: gray_q == bin_q ^ (bin_q >> 1) in every cycle, including after reset and load.
- Single-bit change:
  - Any count step (en, no load) changes exactly one gray_q bit, including wrap.
  - Load may change multiple bits.
- Arithmetic is modulo 2^WIDTH; no carry-out port. Direction may change on any cycle with no dead cycle.

Optional Feature:
- Macro: GRAY_COUNTER_RX_SYNC_EN.
- Defined:
  - Adds input gray_in[WIDTH] (Gray pointer from a foreign clock domain) and output bin_rx[WIDTH].
  - gray_in passes through a 2-flop synchroniser in clk, then Gray-to-binary decode (bin[i] = XOR of gray[WIDTH-1:i]), then an output register.
  - Latency from stable gray_in to bin_rx is 3 clk edges.
  - All stages reset to 0 asynchronously.
- Undefined: ports gray_in and bin_rx do not exist, and no synchroniser flops are instantiated.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=5, assert reset mid-clock -> bin_q=5, gray_q=4'b0111, tc=0 immediately, without a clock edge.
- Up wrap: WIDTH=4, SATURATE=0, load 14, en=1, up=1 for 3 cycles -> bin_q 15, 0, 1; gray_q 1000, 0000, 0001; tc=1 only in the cycle bin_q=0.
- Down saturate: SATURATE=1, load 1, en=1, up=0 for 3 cycles -> bin_q 0, 0, 0; tc high in the 2nd and 3rd cycles.
- Load priority: load=1, load_val=9, en=1, up=1 in the same cycle -> bin_q=9, gray_q=4'b1101, tc=0.
- Gray property: free-run up then down across all 2^WIDTH values -> every step has popcount(gray_q ^ prev) == 1, and the invariant holds every cycle.
- With GRAY_COUNTER_RX_SYNC_EN: drive gray_in=4'b1101 and hold -> bin_rx=9 exactly 3 edges later; reset mid-way -> bin_rx=0 immediately.
